// File: rtl/vlc_pkg.sv
// Shared types and constants for the tail-lamp pattern monitor.
package vlc_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    L1      = 4'd1,
    L2      = 4'd2,
    L3      = 4'd3,
    R1      = 4'd4,
    R2      = 4'd5,
    R3      = 4'd6,
    HAZ     = 4'd7,
    ILLEGAL = 4'd8
  } lamp_class_t;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } vlc_mode_t;

  localparam logic [1:0] FC_PATTERN = 2'd1;
  localparam logic [1:0] FC_TRANS   = 2'd2;
  localparam logic [1:0] FC_HOLD    = 2'd3;

endpackage

// File: rtl/vlc_lamp_classify.sv
// Maps a registered {left,right} lamp pattern onto its sequence class.
module vlc_lamp_classify
  import vlc_pkg::*;
(
  input  logic [2:0]  left_lamp,
  input  logic [2:0]  right_lamp,
  output lamp_class_t lamp_class
);

  // Only thermometer-coded single-side patterns, all-off and all-on are legal
  always_comb begin
    case ({left_lamp, right_lamp})
      6'b000_000: lamp_class = IDLE;
      6'b001_000: lamp_class = L1;
      6'b011_000: lamp_class = L2;
      6'b111_000: lamp_class = L3;
      6'b000_001: lamp_class = R1;
      6'b000_011: lamp_class = R2;
      6'b000_111: lamp_class = R3;
      6'b111_111: lamp_class = HAZ;
      default:    lamp_class = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/vlc_lamp_decoder.sv
// Tail-lamp monitor: recovers the signalled mode and flags illegal
// patterns, illegal pattern steps and patterns held for too long.
module vlc_lamp_decoder
  import vlc_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int IDLE_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] left_lamp,
  input  logic [2:0] right_lamp,
  input  logic       fault_clr,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic       seq_done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       fault_sticky
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int IW = $clog2(IDLE_MAX + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);
  localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_MAX);

  logic [5:0]    r_lamp;
  lamp_class_t   cur_class;
  lamp_class_t   prev_class;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_next;
  logic          hold_fire;
  logic          fault_next;
  logic [1:0]    code_next;
  logic [1:0]    mode_next;
  logic          done_next;

  // Allowed class-to-class steps; a return to IDLE is always a legal cancel
  function automatic logic step_legal(lamp_class_t src, lamp_class_t dst);
    logic ok;
    ok = (src == dst) || (dst == IDLE);
    case (src)
      IDLE:    ok = ok || (dst == L1) || (dst == R1) || (dst == HAZ);
      L1:      ok = ok || (dst == L2) || (dst == HAZ);
      L2:      ok = ok || (dst == L3) || (dst == HAZ);
      R1:      ok = ok || (dst == R2) || (dst == HAZ);
      R2:      ok = ok || (dst == R3) || (dst == HAZ);
      default: ok = ok;
    endcase
    return ok;
  endfunction

  vlc_lamp_classify u_classify (
    .left_lamp  (r_lamp[5:3]),
    .right_lamp (r_lamp[2:0]),
    .lamp_class (cur_class)
  );

  // Next counter values, fault selection (pattern > step > hold) and mode update
  always_comb begin
    hold_next = '0;
    if (cur_class != IDLE && cur_class != ILLEGAL) begin
      if (cur_class == prev_class)
        hold_next = (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + HW'(1);
      else
        hold_next = HW'(1);
    end
    hold_fire = (hold_next == HOLD_LIM) &&
                !((cur_class == prev_class) && (hold_cnt == HOLD_LIM));

    idle_next = '0;
    if (cur_class == IDLE)
      idle_next = (idle_cnt == IDLE_LIM) ? idle_cnt : idle_cnt + IW'(1);

    fault_next = 1'b0;
    code_next  = fault_code;
    if (cur_class == ILLEGAL) begin
      if (prev_class != ILLEGAL) begin
        fault_next = 1'b1;
        code_next  = FC_PATTERN;
      end
    end else if (prev_class != ILLEGAL && !step_legal(prev_class, cur_class)) begin
      fault_next = 1'b1;
      code_next  = FC_TRANS;
    end else if (hold_fire) begin
      fault_next = 1'b1;
      code_next  = FC_HOLD;
    end

    mode_next = mode;
    done_next = 1'b0;
    if (!fault_next) begin
      if (idle_next == IDLE_LIM) begin
        mode_next = OFF;
      end else if (cur_class == L3 && prev_class == L2) begin
        mode_next = LEFT;
        done_next = 1'b1;
      end else if (cur_class == R3 && prev_class == R2) begin
        mode_next = RIGHT;
        done_next = 1'b1;
      end else if (cur_class == HAZ && prev_class != HAZ) begin
        mode_next = HAZARD;
        done_next = 1'b1;
      end
    end
  end

  // Lamp capture, class history, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lamp       <= '0;
      prev_class   <= IDLE;
      hold_cnt     <= '0;
      idle_cnt     <= '0;
      mode         <= OFF;
      mode_valid   <= 1'b0;
      seq_done     <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= '0;
      fault_sticky <= 1'b0;
    end else begin
      r_lamp       <= {left_lamp, right_lamp};
      prev_class   <= cur_class;
      hold_cnt     <= hold_next;
      idle_cnt     <= idle_next;
      mode         <= mode_next;
      mode_valid   <= (mode_next != OFF);
      seq_done     <= done_next;
      fault        <= fault_next;
      fault_code   <= code_next;
      if (fault_next)
        fault_sticky <= 1'b1;
      else if (fault_clr)
        fault_sticky <= 1'b0;
    end
  end

endmodule

// File: doc/vlc_lamp_decoder.md
# vlc_lamp_decoder

Receive-side monitor for the vehicle lighting controller: it watches the six tail-lamp drive lines and recovers the signalled mode (off, left, right, hazard). It also checks every lamp pattern and pattern-to-pattern step against the legal sequence set. It sits beside the controller's lamp outputs, for closed-loop self-test and for reporting faults to the host.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one non-IDLE pattern may persist before a stuck fault is raised.
- `IDLE_MAX`, default 16: consecutive IDLE cycles after which the recovered mode decays to OFF. Must exceed the controller's hazard off-period.
- `clk` input 1: single clock; all state on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `left_lamp` input 3: left lamps, bit0 innermost (LA), bit2 outermost (LC).
- `right_lamp` input 3: right lamps, same bit order.
- `fault_clr` input 1: clears `fault_sticky`.
- `mode` output 2: recovered mode; 0 OFF, 1 LEFT, 2 RIGHT, 3 HAZARD.
- `mode_valid` output 1: high while `mode` is not OFF.
- `seq_done` output 1: one-cycle pulse on completion of a left/right sweep (L3/R3) or on entry to hazard-on (HAZ).
- `fault` output 1: one-cycle pulse per detected fault.
- `fault_code` output 2: cause of the latest fault; 1 illegal pattern, 2 illegal transition, 3 hold overflow. Holds its value until the next fault.
- `fault_sticky` output 1: set by any fault; cleared by `fault_clr`.

## Operation
- Lamps are registered into `r_lamp` each cycle and classified from `{left,right}`:
  - IDLE 000/000;
  - L1 001/000, L2 011/000, L3 111/000;
  - R1 000/001, R2 000/011, R3 000/111;
  - HAZ 111/111;
  - anything else is ILLEGAL.
- `prev_class` register holds the class of the previous cycle.
- Legal steps:
  - same→same, subject to the hold check;
  - IDLE→L1/R1/HAZ;
  - L1→L2→L3→IDLE, and R1→R2→R3→IDLE;
  - HAZ→IDLE;
  - any class→IDLE (cancel);
  - L1/L2/R1/R2→HAZ (hazard override).
  - All other steps are illegal transitions.
- Entry into ILLEGAL: fault code 1, raised once on entry. Repeated ILLEGAL cycles raise no further fault.
- The first step out of ILLEGAL is not checked (resync).
- Hold counter:
  - counts consecutive cycles of the same non-IDLE class, resets to 1 on a class change;
  - on reaching HOLD_MAX with the class unchanged, fault code 3 fires once and the counter saturates;
  - it does not re-fire until the class changes.
- Fault priority in one cycle: code 1 > code 2 > code 3. Only one `fault` pulse is issued.
- Mode recovery:
  - L3 entered from L2 → `mode` = LEFT plus `seq_done`;
  - R3 entered from R2 → RIGHT plus `seq_done`;
  - HAZ entered → HAZARD plus `seq_done`.
- Idle counter: counts consecutive IDLE cycles and saturates at IDLE_MAX. On reaching IDLE_MAX, `mode` becomes OFF.
- A fault does not change `mode`.
- `fault_clr` and a new fault in the same cycle: the fault wins and `fault_sticky` stays 1.

## Timing
- Reset values: all outputs 0; `r_lamp` = 0; `prev_class` = IDLE; both counters 0. Reset takes effect immediately and asynchronously.
- Reset mid-sequence: the first post-reset pattern is checked against IDLE. Resuming at L2 therefore raises code 2.
- Latency: a pattern at the inputs before edge N is registered at N. The resulting `mode`, `seq_done`, `fault` and `fault_code` appear after edge N+1, i.e. 2 cycles.
- `fault_sticky` sets in the same cycle as `fault`. `fault_clr` takes effect at the next edge.
- Mode decay: after IDLE_MAX IDLE cycles, plus the 2-cycle latency.
- Counter widths: $clog2(MAX+1), saturating, with no wrap.

## Structure
- Package `vlc_pkg` holds:
  - `lamp_class_t` enum (IDLE, L1–L3, R1–R3, HAZ, ILLEGAL);
  - `vlc_mode_t` enum (OFF, LEFT, RIGHT, HAZARD);
  - fault code constants `FC_PATTERN`, `FC_TRANS`, `FC_HOLD`.
- Sub-module `vlc_lamp_classify`: purely combinational, 6-bit pattern → `lamp_class_t`.
- Transition legality, both counters and the output registers live in `vlc_lamp_decoder`.

## Test plan
- Left sweep: IDLE, 001, 011, 111, IDLE, each held 2 cycles. Required: `mode`=1, a single `seq_done` pulse, no fault.
- Hazard: alternate 111/111 and 000/000 every 4 cycles for 40 cycles. Required: `mode`=3 throughout, `seq_done` on every on-entry, no fault. Then all-off for 16+ cycles → `mode`=0, `mode_valid`=0.
- Illegal pattern 010/000 held 3 cycles, then IDLE. Required: exactly one `fault` with `fault_code`=1, `fault_sticky`=1, no transition fault on the exit to IDLE.
- Skip step: L1 directly to L3. Required: `fault_code`=2, `mode` unchanged. Stuck R2 for 8 cycles: `fault_code`=3 exactly once.
- Assert `fault_clr` in the same cycle as a new fault → `fault_sticky` stays 1. `fault_clr` alone → `fault_sticky` is 0 after the next edge.
- Assert `rst` asynchronously mid-sweep at L2. Required: all outputs 0 immediately. Releasing reset with the lamps at 111/000 gives `fault_code`=2 two cycles later.
